// File: rtl/wf68k30l_movem_seq_pkg.sv
// Shared definitions for the WF68K30L MOVEM/MOVEP transfer sequencer:
// addressing-mode encodings and the sequencer state type.
package wf68k30l_movem_seq_pkg;

  localparam logic [1:0] MOVEM_CTRL    = 2'd0;  // d16(An), index, absolute
  localparam logic [1:0] MOVEM_POSTINC = 2'd1;  // (An)+
  localparam logic [1:0] MOVEM_PREDEC  = 2'd2;  // -(An)
  localparam logic [1:0] MOVEP_MODE    = 2'd3;  // MOVEP byte-lane transfers

  typedef enum logic [1:0] {
    StIdle,
    StXfer,
    StWb,
    StFin
  } t_movem_seq_state;

endpackage

// File: rtl/wf68k30l_movem_ffs.sv
// Combinational lowest-set-bit encoder used to skip clear register-list bits.
module wf68k30l_movem_ffs #(
  parameter int unsigned NREGS = 16
) (
  input  logic [NREGS-1:0]         i_vec,
  output logic [$clog2(NREGS)-1:0] o_idx,
  output logic                     o_any
);

  localparam int unsigned RW = $clog2(NREGS);

  // Scan from the top down so the lowest set bit is the last to overwrite.
  always_comb begin
    o_idx = '0;
    o_any = |i_vec;
    for (int i = NREGS - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_idx = RW'(i);
      end
    end
  end

endmodule

// File: rtl/wf68k30l_movem_seq.sv
// MOVEM/MOVEP transfer sequencer: issues one register/address pair per bus
// transfer, skipping clear mask bits, then reports the final An writeback.
module wf68k30l_movem_seq
  import wf68k30l_movem_seq_pkg::*;
#(
  parameter int unsigned NREGS  = 16,
  parameter int unsigned ADDR_W = 32
) (
  input  logic                       CLK,
  input  logic                       RESETn,
  input  logic                       START,
  input  logic                       ABORT,
  input  logic [1:0]                 MODE,
  input  logic                       DIR,
  input  logic                       LONG,
  input  logic [NREGS-1:0]           MASK,
  input  logic [2:0]                 AN_SEL,
  input  logic [2:0]                 DN_SEL,
  input  logic [ADDR_W-1:0]          BASE_ADR,
  output logic                       XFER_VALID,
  input  logic                       XFER_RDY,
  output logic [$clog2(NREGS)-1:0]   XFER_REG,
  output logic [ADDR_W-1:0]          XFER_ADR,
  output logic [1:0]                 XFER_BYTE,
  output logic                       XFER_LAST,
  output logic                       XFER_INH_WR,
  output logic                       AN_WB_VALID,
  output logic [ADDR_W-1:0]          AN_WB_ADR,
  output logic                       BUSY,
  output logic                       DONE,
  output logic [$clog2(NREGS):0]     COUNT
);

  localparam int unsigned RW = $clog2(NREGS);

  t_movem_seq_state r_state;
  t_movem_seq_state w_state_nxt;

  logic [NREGS-1:0]  r_pend;
  logic [ADDR_W-1:0] r_adr;
  logic [1:0]        r_lane;
  logic [RW:0]       r_count;
  logic [1:0]        r_mode;
  logic              r_dir;
  logic              r_long;
  logic [2:0]        r_an;
  logic [2:0]        r_dn;

  logic [RW-1:0]     w_ffs_idx;
  logic              w_ffs_any;
  logic [RW-1:0]     w_idx;
  logic [RW-1:0]     w_reg;
  logic [RW:0]       w_an_reg;
  logic [NREGS-1:0]  w_clr;
  logic [RW:0]       w_mask_pop;
  logic [RW:0]       w_start_cnt;
  logic [ADDR_W-1:0] w_size_in;
  logic [ADDR_W-1:0] w_size;
  logic [ADDR_W-1:0] w_adr_step;
  logic              w_start;
  logic              w_hs;
  logic              w_last;
  logic              w_xfer;
  logic              w_wb_mode;

  wf68k30l_movem_ffs #(
    .NREGS (NREGS)
  ) u_ffs (
    .i_vec (r_pend),
    .o_idx (w_ffs_idx),
    .o_any (w_ffs_any)
  );

  // Register-list popcount for the initial transfer count.
  always_comb begin
    w_mask_pop = '0;
    for (int i = 0; i < NREGS; i++) begin
      w_mask_pop = w_mask_pop + (RW+1)'(MASK[i]);
    end
  end

  // Start-time values and per-transfer address/register selection.
  always_comb begin
    w_size_in   = LONG ? ADDR_W'(4) : ADDR_W'(2);
    w_size      = r_long ? ADDR_W'(4) : ADDR_W'(2);
    w_start     = (r_state == StIdle) && START;
    w_start_cnt = (MODE == MOVEP_MODE) ? (LONG ? (RW+1)'(4) : (RW+1)'(2)) : w_mask_pop;
    w_xfer      = (r_state == StXfer);
    w_hs        = w_xfer && XFER_RDY;
    w_last      = (r_count == (RW+1)'(1));
    w_idx       = w_ffs_any ? w_ffs_idx : '0;
    w_clr       = NREGS'(1) << w_ffs_idx;
    w_an_reg    = (RW+1)'(8) + (RW+1)'(r_an);
    w_wb_mode   = (r_mode == MOVEM_POSTINC) || (r_mode == MOVEM_PREDEC);
    // The predecrement list is bit-reversed: mask bit i names register NREGS-1-i.
    unique case (r_mode)
      MOVEM_PREDEC: begin
        w_reg      = RW'(NREGS - 1) - w_idx;
        w_adr_step = r_adr - w_size;
      end
      MOVEP_MODE: begin
        w_reg      = RW'(r_dn);
        w_adr_step = r_adr + ADDR_W'(2);
      end
      default: begin
        w_reg      = w_idx;
        w_adr_step = r_adr + w_size;
      end
    endcase
  end

  // State register.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; ABORT overrides everything, including a same-cycle handshake.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle: begin
        if (START) begin
          w_state_nxt = (w_start_cnt == '0) ? StWb : StXfer;
        end
      end
      StXfer: begin
        if (XFER_RDY && w_last) begin
          w_state_nxt = StWb;
        end
      end
      StWb:    w_state_nxt = StFin;
      StFin:   w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
    if (ABORT) begin
      w_state_nxt = StIdle;
    end
  end

  // Operation context: latched at START, advanced on each accepted transfer.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_pend  <= '0;
      r_adr   <= '0;
      r_lane  <= '0;
      r_count <= '0;
      r_mode  <= MOVEM_CTRL;
      r_dir   <= 1'b0;
      r_long  <= 1'b0;
      r_an    <= '0;
      r_dn    <= '0;
    end else if (ABORT) begin
      r_pend  <= '0;
      r_lane  <= '0;
      r_count <= '0;
    end else if (w_start) begin
      r_pend  <= (MODE == MOVEP_MODE) ? '0 : MASK;
      // Predecrement stores at An-size first.
      r_adr   <= (MODE == MOVEM_PREDEC) ? (BASE_ADR - w_size_in) : BASE_ADR;
      r_lane  <= LONG ? 2'd3 : 2'd1;
      r_count <= w_start_cnt;
      r_mode  <= MODE;
      r_dir   <= DIR;
      r_long  <= LONG;
      r_an    <= AN_SEL;
      r_dn    <= DN_SEL;
    end else if (w_hs) begin
      if (r_mode == MOVEP_MODE) begin
        r_lane <= r_lane - 2'd1;
      end else begin
        r_pend <= r_pend & ~w_clr;
      end
      r_adr   <= w_adr_step;
      r_count <= r_count - (RW+1)'(1);
    end
  end

  // Outputs decoded from registered state; everything reads zero outside its phase.
  always_comb begin
    XFER_VALID  = w_xfer;
    XFER_REG    = w_xfer ? w_reg : '0;
    XFER_ADR    = w_xfer ? r_adr : '0;
    XFER_BYTE   = (w_xfer && (r_mode == MOVEP_MODE)) ? r_lane : 2'd0;
    XFER_LAST   = w_xfer && w_last;
    // Loading An from its own (An)+ list would be overwritten by the postinc writeback.
    XFER_INH_WR = w_xfer && r_dir && (r_mode == MOVEM_POSTINC) &&
                  ({1'b0, w_reg} == w_an_reg);
    AN_WB_VALID = (r_state == StWb) && w_wb_mode;
    // Predecrement r_adr has run one step past the last stored address.
    AN_WB_ADR   = AN_WB_VALID ? ((r_mode == MOVEM_PREDEC) ? (r_adr + w_size) : r_adr) : '0;
    BUSY        = (r_state != StIdle);
    DONE        = (r_state == StFin);
    COUNT       = r_count;
  end

endmodule
